vga_frame_decoder: RTL

VGA_FRAME_DECODER -- requirements
Module: vga_frame_decoder

---
 rtl/vga_frame_decoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_decoder
//  Brief    : Recovers frame timing from a sampled VGA stream, locks onto it,
//             and reports per-frame red bounding box, green pixel count and
//             a saturating timing-error count.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_frame_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Pix_En,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    output logic        Locked,
    output logic        Frame_Done,
    output logic        Red_Valid,
    output logic [9:0]  Red_L,
    output logic [9:0]  Red_R,
    output logic [9:0]  Red_T,
    output logic [9:0]  Red_B,
    output logic [18:0] Green_Count,
    output logic [7:0]  Err_Count
);

    localparam logic [1:0] c_ST_HUNT = 2'd0;
    localparam logic [1:0] c_ST_SYNC = 2'd1;
    localparam logic [1:0] c_ST_LOCK = 2'd2;

    localparam logic [9:0] c_CNT_MAX     = 10'd1023;
    localparam logic [9:0] c_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT_FIRST = 10'(H_ACT_START);
    localparam logic [9:0] c_H_ACT_LAST  = 10'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [9:0] c_V_ACT_FIRST = 10'(V_ACT_START);
    localparam logic [9:0] c_V_ACT_LAST  = 10'(V_ACT_START + V_ACTIVE - 1);

    logic [1:0]  r_state;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic        r_first_hs;

    logic [9:0]  r_work_l;
    logic [9:0]  r_work_r;
    logic [9:0]  r_work_t;
    logic [9:0]  r_work_b;
    logic        r_work_any;
    logic [18:0] r_work_green;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic [9:0]  w_h_next;
    logic        w_active;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic        w_tracking;
    logic        w_line_err;
    logic        w_frame_err;
    logic        w_err_any;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic        w_unused;

    // Blue carries no information for this block; it is only sampled.
    assign w_unused = vga_b;

    // Edge detection on the pixel-rate samples; VS is only looked at on HS edges.
    assign w_hs_fall = Pix_En & r_hs_prev & ~vga_h_sync;
    assign w_vs_fall = w_hs_fall & r_vs_prev & ~vga_v_sync;

    // Position of the current sample: 0 on the HS falling edge, then counting up.
    assign w_h_next = w_hs_fall ? 10'd0 :
                      (r_h_cnt == c_CNT_MAX) ? c_CNT_MAX : (r_h_cnt + 10'd1);

    assign w_active = Pix_En &&
                      (w_h_next >= c_H_ACT_FIRST) && (w_h_next <= c_H_ACT_LAST) &&
                      (r_v_cnt  >= c_V_ACT_FIRST) && (r_v_cnt  <= c_V_ACT_LAST);
    assign w_x = w_h_next - c_H_ACT_FIRST;
    assign w_y = r_v_cnt - c_V_ACT_FIRST;

    // Both checks look at the counters before this edge clears them, so a
    // coincident HS/VS edge sees the line check and the frame check in turn.
    assign w_tracking  = (r_state != c_ST_HUNT);
    assign w_line_err  = w_tracking & w_hs_fall & ~r_first_hs & (r_h_cnt != c_H_LAST);
    assign w_frame_err = w_tracking & w_vs_fall & (r_v_cnt != c_V_LAST);
    assign w_err_any   = w_line_err | w_frame_err;
    assign w_err_inc   = {1'b0, w_line_err} + {1'b0, w_frame_err};
    assign w_err_sum   = {1'b0, Err_Count} + {7'd0, w_err_inc};

    assign Locked = (r_state == c_ST_LOCK);

    // Horizontal/vertical counters and the previous-sync samples.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
        end else if (Pix_En) begin
            r_hs_prev <= vga_h_sync;
            r_h_cnt   <= w_h_next;
            if (w_hs_fall) begin
                r_vs_prev <= vga_v_sync;
                if (w_vs_fall)
                    r_v_cnt <= 10'd0;
                else if (r_v_cnt != c_CNT_MAX)
                    r_v_cnt <= r_v_cnt + 10'd1;
            end
        end
    end

    // Lock state machine: HUNT -> SYNC -> LOCK, any checked error drops to HUNT.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= c_ST_HUNT;
        end else if (w_hs_fall) begin
            if (w_vs_fall) begin
                if (r_state == c_ST_HUNT)
                    r_state <= c_ST_SYNC;
                else
                    r_state <= w_err_any ? c_ST_HUNT : c_ST_LOCK;
            end else if (w_line_err) begin
                r_state <= c_ST_HUNT;
            end
        end
    end

    // The line ending on the first HS edge after (re)hunting has unknown length.
    always_ff @(posedge Clk) begin
        if (reset)
            r_first_hs <= 1'b1;
        else if (w_hs_fall)
            r_first_hs <= w_err_any;
    end

    // Working accumulators for the frame in progress, restarted every VS edge.
    always_ff @(posedge Clk) begin
        if (reset || w_vs_fall) begin
            r_work_l     <= c_CNT_MAX;
            r_work_r     <= 10'd0;
            r_work_t     <= c_CNT_MAX;
            r_work_b     <= 10'd0;
            r_work_any   <= 1'b0;
            r_work_green <= 19'd0;
        end else if (w_tracking && w_active) begin
            if (vga_r) begin
                r_work_any <= 1'b1;
                if (w_x < r_work_l) r_work_l <= w_x;
                if (w_x > r_work_r) r_work_r <= w_x;
                if (w_y < r_work_t) r_work_t <= w_y;
                if (w_y > r_work_b) r_work_b <= w_y;
            end
            if (vga_g)
                r_work_green <= r_work_green + 19'd1;
        end
    end

    // Published results, Frame_Done pulse and the saturating error counter.
    always_ff @(posedge Clk) begin
        if (reset) begin
            Frame_Done  <= 1'b0;
            Red_Valid   <= 1'b0;
            Red_L       <= 10'd0;
            Red_R       <= 10'd0;
            Red_T       <= 10'd0;
            Red_B       <= 10'd0;
            Green_Count <= 19'd0;
            Err_Count   <= 8'd0;
        end else begin
            Frame_Done <= 1'b0;
            if (w_err_any)
                Err_Count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            if (w_vs_fall && w_tracking && !w_err_any) begin
                Frame_Done  <= 1'b1;
                Red_Valid   <= r_work_any;
                Red_L       <= r_work_any ? r_work_l : 10'd0;
                Red_R       <= r_work_any ? r_work_r : 10'd0;
                Red_T       <= r_work_any ? r_work_t : 10'd0;
                Red_B       <= r_work_any ? r_work_b : 10'd0;
                Green_Count <= r_work_green;
            end
        end
    end

endmodule
`default_nettype wire
